// File: rtl/mcpu_soc_gpio_deb.sv
// LED/switch/button MMIO peripheral: 2-flop input synchronisers, per-bit debounce,
// sticky W1C edge status, interrupt enables and a registered level interrupt.

module mcpu_soc_gpio_deb_bit #(
    parameter int DEB_CYCLES = 50000,
    parameter int INVERT     = 0
) (
    input  logic clkrst_core_clk,
    input  logic clkrst_core_rst_n,
    input  logic run,
    input  logic raw,
    output logic stable,
    output logic change,
    output logic rise
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

    logic          s1;
    logic          s2;
    logic          synced;
    logic [CW-1:0] cnt;

    assign synced = (INVERT != 0) ? ~s2 : s2;

    // change marks the edge on which stable takes the synced value
    assign change = run && (synced != stable) && (cnt == CNT_LAST);
    assign rise   = change && synced;

    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            s1     <= 1'b0;
            s2     <= 1'b0;
            cnt    <= '0;
            stable <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
            if (!run || (synced == stable)) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= synced;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

module mcpu_soc_gpio_deb #(
    parameter int N_LEDR         = 10,
    parameter int N_LEDG         = 8,
    parameter int N_SW           = 10,
    parameter int N_BTN          = 4,
    parameter int DEB_CYCLES     = 50000,
    parameter int BTN_ACTIVE_LOW = 1
) (
    input  logic              clkrst_core_clk,
    input  logic              clkrst_core_rst_n,
    input  logic [1:0]        addr,
    input  logic [31:0]       data_in,
    input  logic [31:0]       write_mask,
    output logic [31:0]       data_out,
    input  logic [N_SW-1:0]   ext_switches,
    input  logic [N_BTN-1:0]  ext_buttons,
    output logic [N_LEDR-1:0] ext_led_r,
    output logic [N_LEDG-1:0] ext_led_g,
    output logic              irq
);

    localparam int LW = N_LEDR + N_LEDG;
    localparam logic [31:0] LED_MASK = 32'((64'd1 << LW) - 64'd1);
    localparam logic [31:0] IN_MASK  = 32'(((64'd1 << N_SW) - 64'd1) << 16)
                                     | 32'((64'd1 << N_BTN) - 64'd1);

    localparam logic [1:0] A_LED    = 2'd0;
    localparam logic [1:0] A_INPUT  = 2'd1;
    localparam logic [1:0] A_STATUS = 2'd2;
    localparam logic [1:0] A_IRQ_EN = 2'd3;

    logic [31:0]      led_q;
    logic [31:0]      status_q;
    logic [31:0]      en_q;
    logic             irq_q;
    logic [1:0]       prime_q;
    logic             run;
    logic [N_SW-1:0]  sw_stable;
    logic [N_SW-1:0]  sw_chg;
    logic [N_SW-1:0]  sw_rise;
    logic [N_BTN-1:0] btn_stable;
    logic [N_BTN-1:0] btn_chg;
    logic [N_BTN-1:0] btn_rise;
    logic [31:0]      in_word;
    logic [31:0]      set_word;
    logic [31:0]      clr_word;

    // Debounce waits until the synchronisers hold real samples, so an input
    // held through reset qualifies 2 + DEB_CYCLES edges after release.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) prime_q <= 2'b00;
        else                    prime_q <= {prime_q[0], 1'b1};
    end
    assign run = prime_q[1];

    for (genvar i = 0; i < N_SW; i++) begin : g_sw
        mcpu_soc_gpio_deb_bit #(.DEB_CYCLES(DEB_CYCLES), .INVERT(0)) u_deb (
            .clkrst_core_clk  (clkrst_core_clk),
            .clkrst_core_rst_n(clkrst_core_rst_n),
            .run              (run),
            .raw              (ext_switches[i]),
            .stable           (sw_stable[i]),
            .change           (sw_chg[i]),
            .rise             (sw_rise[i])
        );
    end

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        mcpu_soc_gpio_deb_bit #(.DEB_CYCLES(DEB_CYCLES), .INVERT(BTN_ACTIVE_LOW)) u_deb (
            .clkrst_core_clk  (clkrst_core_clk),
            .clkrst_core_rst_n(clkrst_core_rst_n),
            .run              (run),
            .raw              (ext_buttons[i]),
            .stable           (btn_stable[i]),
            .change           (btn_chg[i]),
            .rise             (btn_rise[i])
        );
    end

    // Switches flag any stable change, buttons flag presses only.
    always_comb begin
        in_word                 = '0;
        in_word[16 +: N_SW]     = sw_stable;
        in_word[0 +: N_BTN]     = btn_stable;
        set_word                = '0;
        set_word[16 +: N_SW]    = sw_chg | (sw_rise & ~sw_rise);
        set_word[0 +: N_BTN]    = btn_rise | (btn_chg & ~btn_chg);
        clr_word                = (addr == A_STATUS) ? (data_in & write_mask) : '0;
    end

    // There is no handshake: any set write_mask bit at a clock edge writes that
    // bit of the word at addr; reads are combinational and side-effect free.
    always_ff @(posedge clkrst_core_clk or negedge clkrst_core_rst_n) begin
        if (!clkrst_core_rst_n) begin
            led_q    <= '0;
            status_q <= '0;
            en_q     <= '0;
            irq_q    <= 1'b0;
        end else begin
            if (addr == A_LED)
                led_q <= ((led_q & ~write_mask) | (data_in & write_mask)) & LED_MASK;
            if (addr == A_IRQ_EN)
                en_q <= ((en_q & ~write_mask) | (data_in & write_mask)) & IN_MASK;
            // set is ORed after the clear so a same-cycle set wins
            status_q <= ((status_q & ~clr_word) | set_word) & IN_MASK;
            irq_q    <= |(status_q & en_q);
        end
    end

    always_comb begin
        data_out = '0;
        case (addr)
            A_LED:    data_out = led_q;
            A_INPUT:  data_out = in_word;
            A_STATUS: data_out = status_q;
            A_IRQ_EN: data_out = en_q;
            default:  data_out = '0;
        endcase
    end

    assign ext_led_g = led_q[N_LEDG-1:0];
    assign ext_led_r = led_q[LW-1:N_LEDG];
    assign irq       = irq_q;

endmodule
